// File: rtl/nvram_upload_reader_if.sv
// Port bundle for nvram_upload_reader: HPS ioctl upload signals and the game RAM arbiter port.
// The master modport is the environment (hps_io + RAM arbiter); slave is the reader itself.
interface nvram_upload_reader_if #(
    parameter int RAM_AW   = 8,
    parameter int IOCTL_AW = 25
);
    logic                ioctl_upload;
    logic [7:0]          ioctl_index;
    logic                ioctl_rd;
    logic [IOCTL_AW-1:0] ioctl_addr;
    logic [7:0]          ioctl_din;
    logic                ioctl_wait;
    logic                ram_req;
    logic [RAM_AW-1:0]   ram_addr;
    logic                ram_gnt;
    logic [7:0]          ram_q;

    modport master (
        output ioctl_upload, ioctl_index, ioctl_rd, ioctl_addr, ram_gnt, ram_q,
        input  ioctl_din, ioctl_wait, ram_req, ram_addr
    );

    modport slave (
        input  ioctl_upload, ioctl_index, ioctl_rd, ioctl_addr, ram_gnt, ram_q,
        output ioctl_din, ioctl_wait, ram_req, ram_addr
    );
endinterface

// File: rtl/nvram_upload_reader.sv
// Serves HPS ioctl upload reads from game work RAM via a request/grant arbiter port.
// Optional macro NVRAM_UPLOAD_CHECKSUM_EN appends a byte that zeroes the 8-bit image sum.
module nvram_upload_reader #(
    parameter int         RAM_AW       = 8,
    parameter int         IOCTL_AW     = 25,
    parameter logic [7:0] UPLOAD_INDEX = 8'd4,
    parameter int         GNT_TIMEOUT  = 64
) (
    input  logic                 clk_sys,
    input  logic                 Reset_I,
    nvram_upload_reader_if.slave bus,
    output logic                 busy,
    output logic                 err,
    output logic                 done
);
    localparam int                  CNT_W = $clog2(GNT_TIMEOUT + 1);
    localparam logic [IOCTL_AW-1:0] DEPTH = IOCTL_AW'(2 ** RAM_AW);

    typedef enum logic [1:0] {IDLE, REQ, CAPT} state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic              sel, sel_q;
    logic              load, oor, timeout, capt;
    logic [7:0]        din_r, oor_byte;
    logic [RAM_AW-1:0] addr_r;

    assign sel = bus.ioctl_upload && (bus.ioctl_index == UPLOAD_INDEX);

`ifdef NVRAM_UPLOAD_CHECKSUM_EN
    logic [7:0] cksum;

    function automatic logic [7:0] cksum_add(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction

    // The trailer byte at DEPTH is the two's complement of the running sum.
    assign oor_byte = (bus.ioctl_addr == DEPTH) ? (8'h00 - cksum) : 8'hFF;
`else
    assign oor_byte = 8'hFF;
`endif

    always_ff @(posedge clk_sys or negedge Reset_I) begin
        if (!Reset_I) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        oor       = 1'b0;
        timeout   = 1'b0;
        capt      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.ioctl_rd && sel) begin
                    if (bus.ioctl_addr < DEPTH) begin
                        load      = 1'b1;
                        state_nxt = REQ;
                    end else begin
                        oor = 1'b1;
                    end
                end
            end
            REQ: begin
                // Session end wins over a same-cycle grant so the HPS is never left stalled.
                if (!sel) begin
                    state_nxt = IDLE;
                end else if (bus.ram_gnt) begin
                    state_nxt = CAPT;
                end else if (cnt == CNT_W'(GNT_TIMEOUT - 1)) begin
                    timeout   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            CAPT: begin
                capt      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or negedge Reset_I) begin
        if (!Reset_I) begin
            din_r  <= 8'h00;
            addr_r <= '0;
            cnt    <= '0;
            err    <= 1'b0;
            done   <= 1'b0;
            sel_q  <= 1'b0;
`ifdef NVRAM_UPLOAD_CHECKSUM_EN
            cksum  <= 8'h00;
`endif
        end else begin
            sel_q <= sel;
            done  <= sel_q && !sel;
            cnt   <= (state == REQ) ? cnt + 1'b1 : '0;
            if (load)    addr_r <= bus.ioctl_addr[RAM_AW-1:0];
            if (oor)     din_r  <= oor_byte;
            if (timeout) din_r  <= 8'h00;
            if (capt)    din_r  <= bus.ram_q;
            if (sel && !sel_q) err <= 1'b0;
            else if (timeout)  err <= 1'b1;
`ifdef NVRAM_UPLOAD_CHECKSUM_EN
            if (sel && !sel_q) cksum <= 8'h00;
            else if (capt)     cksum <= cksum_add((addr_r == '0) ? 8'h00 : cksum, bus.ram_q);
`endif
        end
    end

    assign bus.ioctl_din  = din_r;
    assign bus.ioctl_wait = (state != IDLE);
    assign bus.ram_req    = (state == REQ);
    assign bus.ram_addr   = addr_r;
    assign busy           = (state != IDLE);
endmodule

// File: tb/tb_nvram_upload_reader.sv
// Directed bench for nvram_upload_reader: a time-stamped fetch model checked every cycle plus literal checks.
module tb_nvram_upload_reader;
    localparam int GNT_TIMEOUT = 64;
`ifdef NVRAM_UPLOAD_CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    logic clk_sys = 1'b0;
    logic rst_n   = 1'b0;
    logic busy, err, done;

    nvram_upload_reader_if #(.RAM_AW(8), .IOCTL_AW(25)) bus ();

    nvram_upload_reader #(
        .RAM_AW(8), .IOCTL_AW(25), .UPLOAD_INDEX(8'd4), .GNT_TIMEOUT(GNT_TIMEOUT)
    ) dut (
        .clk_sys(clk_sys),
        .Reset_I(rst_n),
        .bus    (bus),
        .busy   (busy),
        .err    (err),
        .done   (done)
    );

    always #5 clk_sys = ~clk_sys;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    logic [7:0] mem [256];

    // RAM behind the arbiter: data appears the cycle after the grant.
    always @(posedge clk_sys)
        if (bus.ram_gnt) bus.ram_q <= mem[bus.ram_addr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: a fetch is "pending" from acceptance until the byte is delivered; it has an
    // absolute timeout cycle and is "ready" once the grant has been seen.
    int         cyc;
    bit         m_pend, m_ready, m_selp, m_done, m_err;
    int         m_deadline;
    logic [7:0] m_addr, m_din, m_sum;

    always @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            cyc <= 0; m_pend <= 0; m_ready <= 0; m_selp <= 0; m_done <= 0; m_err <= 0;
            m_deadline <= 0; m_addr <= 0; m_din <= 0; m_sum <= 0;
        end else begin
            automatic bit sel = bus.ioctl_upload && (bus.ioctl_index == 8'd4);
            cyc    <= cyc + 1;
            m_selp <= sel;
            m_done <= m_selp && !sel;
            if (sel && !m_selp) begin
                m_err <= 0;
                m_sum <= 0;
            end
            if (!m_pend) begin
                if (bus.ioctl_rd && sel) begin
                    if (bus.ioctl_addr < 256) begin
                        m_pend     <= 1;
                        m_addr     <= bus.ioctl_addr[7:0];
                        m_deadline <= cyc + GNT_TIMEOUT;
                    end else begin
                        m_din <= (CK && bus.ioctl_addr == 256) ? 8'h00 - m_sum : 8'hFF;
                    end
                end
            end else if (m_ready) begin
                m_din   <= mem[m_addr];
                m_sum   <= ((m_addr == 0) ? 8'h00 : m_sum) + mem[m_addr];
                m_pend  <= 0;
                m_ready <= 0;
            end else if (!sel) begin
                m_pend <= 0;
            end else if (bus.ram_gnt) begin
                m_ready <= 1;
            end else if (cyc == m_deadline) begin
                m_pend <= 0;
                m_din  <= 8'h00;
                m_err  <= 1;
            end
        end
    end

    always @(posedge clk_sys) begin
        #1;
        if (chk_en) begin
            check("din",  bus.ioctl_din,  m_din);
            check("wait", bus.ioctl_wait, m_pend);
            check("req",  bus.ram_req,    m_pend && !m_ready);
            check("busy", busy,           m_pend);
            check("err",  err,            m_err);
            check("done", done,           m_done);
            if (m_pend && !m_ready) check("ram_addr", bus.ram_addr, m_addr);
        end
    end

    // Issue one read; grant d cycles into the fetch (0 = never). Optionally re-strobe while busy.
    task automatic do_read(input int a, input int d, input bit dup, output int wcyc);
        @(negedge clk_sys);
        bus.ioctl_rd   = 1'b1;
        bus.ioctl_addr = 25'(a);
        @(negedge clk_sys);
        bus.ioctl_rd = 1'b0;
        wcyc = 0;
        for (int i = 0; i < 200; i++) begin
            if (bus.ioctl_wait) wcyc++;
            else break;
            bus.ram_gnt  = (d > 0 && i == d - 1);
            bus.ioctl_rd = (dup && i == 1);
            if (dup && i == 1) bus.ioctl_addr = 25'(a + 1);
            @(negedge clk_sys);
        end
        bus.ram_gnt  = 1'b0;
        bus.ioctl_rd = 1'b0;
        check("wait_bound", bus.ioctl_wait, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, dcount;
        bus.ioctl_upload = 0; bus.ioctl_index = 0; bus.ioctl_rd = 0;
        bus.ioctl_addr = 0; bus.ram_gnt = 0; bus.ram_q = 0;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i * 7 + 3);
        mem[5] = 8'h3C;

        #1;
        check("rst_din",  bus.ioctl_din,  8'h00);
        check("rst_wait", bus.ioctl_wait, 1'b0);
        check("rst_req",  bus.ram_req,    1'b0);
        check("rst_addr", bus.ram_addr,   8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_err",  err,  1'b0);
        check("rst_done", done, 1'b0);
        repeat (3) @(negedge clk_sys);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // Basic fetch, grant three cycles after the strobe.
        bus.ioctl_upload = 1; bus.ioctl_index = 8'd4;
        repeat (2) @(negedge clk_sys);
        do_read(5, 3, 1'b0, w);
        check("t1_wait_cycles", w, 4);
        check("t1_din", bus.ioctl_din, 8'h3C);
        check("t1_busy", busy, 1'b0);

        // Minimum latency plus a strobe while busy that must be ignored.
        do_read(12, 1, 1'b1, w);
        check("min_wait_cycles", w, 2);
        check("min_din", bus.ioctl_din, 8'h57);

        // Index mismatch: nothing happens.
        bus.ioctl_index = 8'd2;
        repeat (2) @(negedge clk_sys);
        do_read(5, 0, 1'b0, w);
        check("mis_wait_cycles", w, 0);
        check("mis_din", bus.ioctl_din, 8'h57);
        bus.ioctl_index = 8'd4;
        repeat (2) @(negedge clk_sys);

`ifdef NVRAM_UPLOAD_CHECKSUM_EN
        for (int i = 0; i < 256; i++) mem[i] = 8'h01;
        for (int i = 0; i < 256; i++) do_read(i, 1, 1'b0, w);
        do_read(256, 0, 1'b0, w);
        check("ck_wait_cycles", w, 0);
        check("ck_trailer", bus.ioctl_din, 8'h00);
        do_read(257, 0, 1'b0, w);
        check("ck_beyond", bus.ioctl_din, 8'hFF);
        for (int i = 0; i < 256; i++) mem[i] = 8'(i * 7 + 3);
`else
        do_read(256, 0, 1'b0, w);
        check("oor_wait_cycles", w, 0);
        check("oor_din", bus.ioctl_din, 8'hFF);
        do_read(12, 1, 1'b0, w);
        do_read(25'h1FF_FFFF, 0, 1'b0, w);
        check("oor_top_din", bus.ioctl_din, 8'hFF);
`endif

        // Grant timeout, then a normal fetch with err still set.
        do_read(7, 0, 1'b0, w);
        check("to_wait_cycles", w, GNT_TIMEOUT);
        check("to_din", bus.ioctl_din, 8'h00);
        check("to_err", err, 1'b1);
        do_read(8, 2, 1'b0, w);
        check("after_to_din", bus.ioctl_din, 8'h3B);
        check("after_to_err", err, 1'b1);

        // Session ends mid-request.
        @(negedge clk_sys);
        bus.ioctl_rd = 1; bus.ioctl_addr = 25'd9;
        @(negedge clk_sys);
        bus.ioctl_rd = 0;
        check("ab_req_before", bus.ram_req, 1'b1);
        bus.ioctl_upload = 0;
        dcount = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_sys);
            if (i == 0) begin
                check("ab_req",  bus.ram_req,    1'b0);
                check("ab_wait", bus.ioctl_wait, 1'b0);
            end
            if (done) dcount++;
            bus.ram_gnt = (i == 1);
        end
        bus.ram_gnt = 0;
        check("ab_done_pulses", dcount, 1);
        check("ab_din", bus.ioctl_din, 8'h3B);
        check("ab_busy", busy, 1'b0);
        bus.ioctl_upload = 1;
        repeat (2) @(negedge clk_sys);
        check("new_session_err", err, 1'b0);

        // Reset during a request.
        @(negedge clk_sys);
        bus.ioctl_rd = 1; bus.ioctl_addr = 25'd10;
        @(negedge clk_sys);
        bus.ioctl_rd = 0;
        #2 rst_n = 0;
        #1;
        check("rr_req",  bus.ram_req,    1'b0);
        check("rr_wait", bus.ioctl_wait, 1'b0);
        check("rr_din",  bus.ioctl_din,  8'h00);
        check("rr_addr", bus.ram_addr,   8'h00);
        check("rr_busy", busy, 1'b0);
        @(negedge clk_sys);
        rst_n = 1;
        bus.ram_gnt = 1;
        @(negedge clk_sys);
        bus.ram_gnt = 0;
        check("rr_gnt_ignored", busy, 1'b0);
        do_read(11, 1, 1'b0, w);
        check("rr_next_wait_cycles", w, 2);
        check("rr_next_din", bus.ioctl_din, 8'h50);

        repeat (3) @(negedge clk_sys);
        chk_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/nvram_upload_reader.md
Name: nvram_upload_reader

Overview:
- Read side of the HPS ioctl stream, the mirror of the ROM download path.
- When the HPS requests an upload (save file) for the configured index, the block services each ioctl_rd strobe by fetching one byte from the game's work RAM through an arbitrated request/grant port.
- It presents the byte on ioctl_din, stalling the HPS with ioctl_wait until the byte is valid.
- Sits between hps_io and the game RAM arbiter in the emu top, clocked on clk_sys.

Parameters:
- RAM_AW, 8, game RAM address width; upload image length DEPTH = 2**RAM_AW bytes.
- IOCTL_AW, 25, ioctl_addr width.
- UPLOAD_INDEX, 8'd4, ioctl_index value this block answers to.
- GNT_TIMEOUT, 64, clk_sys cycles to wait for ram_gnt before aborting one byte.

Ports:
- clk_sys  in  1  system clock, all logic on rising edge.
- Reset_I  in  1  asynchronous, active-low reset.
- ioctl_upload  in  1  HPS upload session active.
- ioctl_index  in  8  file index of current session.
- ioctl_rd  in  1  one-cycle read strobe from HPS.
- ioctl_addr  in  IOCTL_AW  byte address, valid with ioctl_rd.
- ioctl_din  out  8  returned byte.
- ioctl_wait  out  1  stall to HPS; high while a byte is being fetched.
- ram_req  out  1  request to RAM arbiter.
- ram_addr  out  RAM_AW  RAM address; stable while ram_req is high.
- ram_gnt  in  1  one-cycle grant; the RAM samples ram_addr on this cycle.
- ram_q  in  8  RAM data, valid the cycle after ram_gnt.
- busy  out  1  FSM not in IDLE.
- err  out  1  sticky: a grant timeout occurred in this session.
- done  out  1  one-cycle pulse on falling edge of a matching ioctl_upload.

Behaviour:
- Reset values (async, Reset_I=0):
  - ioctl_din=8'h00, ioctl_wait=0, ram_req=0, ram_addr=0, busy=0, err=0, done=0.
  - FSM in IDLE; checksum accumulator=0; upload-edge register=0.
- Session match: sel = ioctl_upload && (ioctl_index==UPLOAD_INDEX). ioctl_rd is ignored when sel=0.
- IDLE:
  - On ioctl_rd && sel && ioctl_addr < DEPTH: latch ram_addr = ioctl_addr[RAM_AW-1:0]; next cycle ioctl_wait=1, ram_req=1; go REQ.
  - On ioctl_rd && sel && ioctl_addr >= DEPTH: ioctl_din=8'hFF next cycle; no wait, no RAM access; stay IDLE.
- REQ:
  - Hold ram_req and ram_addr; count cycles.
  - On ram_gnt: drop ram_req next cycle; go CAPT.
  - If the count reaches GNT_TIMEOUT without a grant: ioctl_din=8'h00, err=1, ioctl_wait=0, ram_req=0; go IDLE.
- CAPT (one cycle):
  - ioctl_din <= ram_q; checksum <= checksum + ram_q (mod 256); checksum cleared first when ram_addr==0.
  - ioctl_wait=0; go IDLE.
- Latency:
  - ioctl_rd at cycle 0 → ioctl_wait high from cycle 1.
  - ram_gnt at cycle k → ioctl_din valid and ioctl_wait low at cycle k+2.
  - Minimum latency: 3 cycles (grant at cycle 1).
- ioctl_rd arriving while busy=1 is a protocol violation: ignored, no state change.
- ioctl_upload falls mid-fetch:
  - REQ aborts immediately: ram_req=0, ioctl_wait=0, FSM→IDLE.
  - done pulses on the edge.
  - err and checksum clear on the next rising edge of a matching ioctl_upload.
- Reset mid-fetch: all outputs return to reset values asynchronously; a pending grant is ignored after release.
- ram_gnt while ram_req=0: ignored.

Optional Feature:
- Macro NVRAM_UPLOAD_CHECKSUM_EN.
- Defined:
  - Image length is DEPTH+1 bytes.
  - A read of address DEPTH returns (8'h00 - checksum) without RAM access or wait, so the 8-bit sum of the whole image is 0.
  - Addresses > DEPTH return 8'hFF.
- Undefined: no checksum logic; addresses >= DEPTH return 8'hFF.

Test Plan:
- Reset then upload index 4; rd addr 0x05 with RAM[5]=0x3C; grant 3 cycles after req → ioctl_wait high 4 cycles, then ioctl_din=0x3C, wait low, busy low.
- Upload index 2 (mismatch); pulse rd → no ram_req, ioctl_wait stays 0, ioctl_din unchanged.
- Index 4; rd addr 0x100 (DEPTH=256), macro off → ioctl_din=0xFF, no wait. Macro on, RAM filled with 0x01 and addresses 0..255 read in order → rd 0x100 returns 0x00; rd 0x101 returns 0xFF.
- ram_gnt held low → after 64 cycles ioctl_din=0x00, err=1, wait low; next byte with a normal grant still returns correct data, err stays 1.
- Drop ioctl_upload during REQ → same cycle-plus-one ram_req=0, wait=0; done pulses exactly one cycle; a later grant pulse causes no change.
- Assert Reset_I low while in REQ → all outputs 0 immediately; after release, a new rd is served normally.
